// File: rtl/ldst_pkg.sv
// Shared definitions for the load/store sequencer.
//   state_t        : sequencer state encoding
//   DEF_LOAD_OPC   : default load opcode value
//   DEF_STORE_OPC  : default store opcode value
//   cnt_width()    : bits needed for a wait counter that runs 0..timeout-1
package ldst_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam int unsigned DEF_LOAD_OPC  = 11;
   localparam int unsigned DEF_STORE_OPC = 12;

   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/ldst_wait_timer.sv
// Bounded wait counter for a bus master.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous clear to zero (has priority over enable)
//   enable     : count one cycle
//   expired    : counter currently holds TIMEOUT-1 (last allowed wait cycle)
module ldst_wait_timer
   import ldst_pkg::*;
#(
   parameter  int unsigned TIMEOUT = 15,
   localparam int unsigned CNT_W   = cnt_width(TIMEOUT)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + CNT_W'(1);
   end

   assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ldst_ctrl_fsm.sv
// Load/store sequencer between instruction decoder, register file and memory bus.
// Owns MAR/MDR, forms base+offset addresses, bounds the wait on mem_mfc.
//   start/opcode/rd_idx/ra_idx/offset : request, sampled when accepted in IDLE
//   rf_raddr/rf_rdata                 : combinational register file read port
//   rf_we/rf_waddr/rf_wdata           : register file write port (load writeback)
//   mem_en/mem_rw/mem_addr/mem_wdata  : memory request (mem_rw 1 = read)
//   mem_rdata/mem_mfc                 : memory response
//   busy/done/err                     : status; done pulses once per operation
// All outputs decode registered state only.
module ldst_ctrl_fsm
   import ldst_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned REG_AW    = 4,
   parameter int unsigned OPC_W     = 4,
   parameter int unsigned LOAD_OPC  = DEF_LOAD_OPC,
   parameter int unsigned STORE_OPC = DEF_STORE_OPC,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [REG_AW-1:0] rd_idx,
   input  logic [REG_AW-1:0] ra_idx,
   input  logic [ADDR_W-1:0] offset,
   output logic [REG_AW-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_mfc,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t            state_q, state_d;
   logic [OPC_W-1:0]  opc_q;
   logic [REG_AW-1:0] rd_q, ra_q;
   logic [ADDR_W-1:0] off_q, mar_q;
   logic [DATA_W-1:0] mdr_q;
   logic              err_q;
   logic              is_load, legal_in;
   logic              tmr_clear, tmr_en, tmr_expired;

   assign is_load  = (opc_q == OPC_W'(LOAD_OPC));
   assign legal_in = (opcode == OPC_W'(LOAD_OPC)) || (opcode == OPC_W'(STORE_OPC));

   // Held at zero outside MEM so every MEM visit starts counting from 0.
   assign tmr_clear = (state_q != S_MEM);
   assign tmr_en    = (state_q == S_MEM) && !mem_mfc && !tmr_expired;

   ldst_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = legal_in ? S_ADDR : S_DONE;
         S_ADDR: state_d = is_load ? S_MEM : S_DATA;
         S_DATA: state_d = S_MEM;
         S_MEM: begin
            // MFC wins over expiry, so a response in the last allowed cycle succeeds.
            if (mem_mfc)          state_d = is_load ? S_WB : S_DONE;
            else if (tmr_expired) state_d = S_DONE;
         end
         S_WB:   state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opc_q <= '0;
         rd_q  <= '0;
         ra_q  <= '0;
         off_q <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         err_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  opc_q <= opcode;
                  rd_q  <= rd_idx;
                  ra_q  <= ra_idx;
                  off_q <= offset;
                  err_q <= !legal_in;
               end
            end
            S_ADDR: mar_q <= rf_rdata[ADDR_W-1:0] + off_q;
            S_DATA: mdr_q <= rf_rdata;
            S_MEM: begin
               if (mem_mfc) begin
                  if (is_load) mdr_q <= mem_rdata;
               end else if (tmr_expired) begin
                  err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rf_raddr  = (state_q == S_DATA) ? rd_q : ra_q;
   assign rf_we     = (state_q == S_WB);
   assign rf_waddr  = rd_q;
   assign rf_wdata  = mdr_q;
   assign mem_en    = (state_q == S_MEM);
   assign mem_rw    = (state_q == S_MEM) && is_load;
   assign mem_addr  = mar_q;
   assign mem_wdata = mdr_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;

endmodule

// File: doc/ldst_ctrl_fsm.md
Name: ldst_ctrl_fsm

Overview:
Parametrised load/store sequencer between the instruction decoder, the register file and the memory bus.
- Owns the address (MAR) and data (MDR) registers internally.
- Computes a base+offset effective address.
- Adds a bounded wait on memory-function-complete (MFC) and reports errors.
- Pulses `done` to trigger the next instruction fetch.

Parameters:
- DATA_W, 16, register/memory data width
- ADDR_W, 16, memory address width; DATA_W >= ADDR_W
- REG_AW, 4, register index width (2^REG_AW registers)
- OPC_W, 4, opcode width
- LOAD_OPC, 11, load opcode value
- STORE_OPC, 12, store opcode value
- TIMEOUT, 15, maximum cycles spent in MEM waiting for mem_mfc; must be >= 1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- opcode  in  OPC_W  instruction opcode, sampled on accept
- rd_idx  in  REG_AW  data register (store source / load destination), sampled on accept
- ra_idx  in  REG_AW  base-address register, sampled on accept
- offset  in  ADDR_W  address offset, sampled on accept
- rf_raddr  out  REG_AW  register file read index (combinational read)
- rf_rdata  in  DATA_W  register file read data, same cycle
- rf_we  out  1  register file write strobe
- rf_waddr  out  REG_AW  register file write index
- rf_wdata  out  DATA_W  register file write data
- mem_en  out  1  memory request
- mem_rw  out  1  1 = read, 0 = write
- mem_addr  out  ADDR_W  memory address (MAR)
- mem_wdata  out  DATA_W  memory write data (MDR)
- mem_rdata  in  DATA_W  memory read data, valid with mem_mfc
- mem_mfc  in  1  memory function complete
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse (instruction-fetch trigger)
- err  out  1  error status of the last operation

Behaviour:
- Reset, asynchronous, also mid-operation:
  - state=IDLE, MAR=0, MDR=0, wait counter=0, err=0, latched fields=0.
  - All strobes (rf_we, mem_en, done, busy) drop immediately.
  - Any in-flight memory access is abandoned.
- Outputs are decoded from registered state and registers only; no combinational path from inputs to outputs.
- States: IDLE, ADDR, DATA, MEM, WB, DONE.
- IDLE:
  - On start=1, latch opcode, rd_idx, ra_idx and offset, and clear err.
  - Legal opcode -> ADDR.
  - Illegal opcode -> DONE with err=1.
  - start is ignored while busy.
- ADDR: rf_raddr=ra_idx. At the clock edge, MAR <= rf_rdata[ADDR_W-1:0] + offset, modulo 2^ADDR_W (wraps, no error). Next state is DATA for a store, MEM for a load.
- DATA (store only): rf_raddr=rd_idx. At the clock edge, MDR <= rf_rdata. Next state is MEM.
- MEM:
  - Drives mem_en=1, mem_rw=(load), mem_addr=MAR, mem_wdata=MDR.
  - The wait counter is 0 on entry.
  - mem_mfc=1: a load captures MDR <= mem_rdata; next state is WB for a load, DONE for a store.
  - Otherwise, if counter==TIMEOUT-1: err=1 -> DONE, with no register write.
  - Otherwise the counter increments.
  - An MFC arriving in the final allowed cycle is a success.
  - mem_en is held continuously through the wait; it never deasserts between retries.
- WB: rf_we=1, rf_waddr=rd_idx, rf_wdata=MDR for one cycle -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- err:
  - Valid while done is high.
  - Held until the next accepted start.
- Latency, start cycle = 0, MFC on the first MEM cycle: done is high at cycle 4 for both load and store.
  - Store: ADDR c1, DATA c2, MEM c3, DONE c4.
  - Load: ADDR c1, MEM c2, WB c3, DONE c4.
  - Each extra wait cycle adds 1.
- Illegal opcode: done at cycle 1. A start held high through DONE is not re-accepted until IDLE.
- Inputs other than rf_rdata, mem_rdata and mem_mfc are ignored after accept.

Decomposition:
- Package ldst_pkg:
  - state enumeration;
  - default LOAD_OPC/STORE_OPC constants;
  - helper function for counter width, clog2(TIMEOUT).
- One sub-module is natural: ldst_wait_timer (clear, enable, expired at TIMEOUT-1), reusable by future bus masters.

Test Plan:
- Store: R3=0x0100, R5=0xBEEF, start with opcode=12, ra=3, rd=5, offset=0x0010, MFC on the first MEM cycle -> one write cycle with mem_addr=0x0110, mem_wdata=0xBEEF, mem_rw=0; done at cycle 4; err=0.
- Load: R2=0x2000, offset=0x0004, memory returns 0x1234 after 3 wait cycles -> rf_we pulse with rf_waddr=rd, rf_wdata=0x1234; done at cycle 7; mem_en high for 4 consecutive cycles.
- Timeout: TIMEOUT=15 with mem_mfc tied 0 -> mem_en high for exactly 15 cycles, no rf_we, done with err=1. Repeat with MFC on the 15th MEM cycle -> success, err=0.
- Illegal opcode 7 -> done at cycle 1, err=1, no mem_en or rf_we ever; the next legal start clears err.
- Wrap and overlap:
  - base=0xFFF8, offset=0x0010 -> mem_addr=0x0008.
  - start pulsed during MEM -> ignored, exactly one done.
- Reset asserted mid-MEM -> mem_en, busy and done low immediately; the next start runs normally from IDLE.
